shift_right_seq_32b: RTL and testbench
======================================

SHIFT_RIGHT_SEQ_32B -- requirements
Module: shift_right_seq_32b

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data width; legal values are powers of two from 8 to 64.
REQ-002 SHALL derive localparam SHW = log2(WIDTH), default 5, shift-amount width and stage count.
REQ-003 SHALL provide port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port start_i  input  1  request; sampled only while busy_o=0.
REQ-006 SHALL provide port arith_i  input  1  mode: 0 = logical right shift (SRL), 1 = arithmetic right shift (SRA).
REQ-007 SHALL provide port in_i  input  WIDTH  operand.
REQ-008 SHALL provide port shamt_i  input  SHW  shift amount, unsigned.
REQ-009 SHALL provide port out_o  output  WIDTH  registered result.
REQ-010 SHALL provide port busy_o  output  1  high while a shift is in progress.
REQ-011 SHALL provide port done_o  output  1  one-cycle pulse; out_o is valid in that cycle.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-013 Accept: start_i=1 in IDLE or DONE SHALL load in_i, shamt_i, arith_i and the sign bit in_i[WIDTH-1] into internal registers, clear the stage counter, and enter SHIFT.
REQ-014 start_i=0 in DONE SHALL return the FSM to IDLE; start_i in IDLE with start_i=0 SHALL hold IDLE.
REQ-015 SHIFT SHALL run exactly SHW cycles; in cycle k (k=0..SHW-1) the working value SHALL shift right by 2^k when captured shamt bit k is 1, otherwise it holds.
REQ-016 Fill bits SHALL be 0 when arith=0 and the captured sign bit when arith=1.
REQ-017 After stage SHW-1, the FSM SHALL write the working value to out_o and enter DONE.
REQ-018 Latency SHALL be fixed: start accepted in cycle N gives done_o=1 in cycle N+SHW+1 (N+6 for WIDTH=32), independent of shamt and mode.
REQ-019 busy_o SHALL be 1 exactly while the FSM is in SHIFT; done_o SHALL be 1 exactly while the FSM is in DONE.
REQ-020 start_i while busy_o=1 SHALL be ignored; in-flight operands and the result SHALL be unaffected.
REQ-021 Operand inputs SHALL be don't-care after acceptance; changes mid-operation SHALL NOT affect the result.
REQ-022 out_o SHALL hold its last value through IDLE and through the SHIFT phase of the next operation, changing only at entry to DONE.
REQ-023 Back-to-back operation: start_i=1 in a DONE cycle SHALL be accepted, giving one done_o pulse every SHW+1 cycles.
REQ-024 shamt=0 SHALL return in_i unchanged; shamt=WIDTH-1 SHALL return 0 or 1 (SRL) or all-sign-bits (SRA).
REQ-025 Result SHALL equal in_i >> shamt (SRL) or $signed(in_i) >>> shamt (SRA).

Reset
REQ-026 rst_i=1 SHALL force IDLE, out_o=0, busy_o=0, done_o=0, and clear all internal registers, without waiting for a clock edge.
REQ-027 Reset asserted during SHIFT or DONE SHALL abort the operation; no done_o SHALL follow for it.
REQ-028 The first start_i after reset deassertion SHALL be accepted on the next rising edge.

Verification
REQ-029 SRA: in=0x80000000, shamt=31, arith=1 -> done_o in cycle N+6, out_o=0xFFFFFFFF; same operands with arith=0 -> out_o=0x00000001.
REQ-030 Identity and mixed: in=0xDEADBEEF, shamt=0 -> 0xDEADBEEF; in=0xF0F0F0F0, shamt=4, SRA -> 0xFF0F0F0F; SRL -> 0x0F0F0F0F.
REQ-031 Busy protection: start in=0x00000100, shamt=8; pulse start_i with in=0xFFFFFFFF in cycle N+2 -> single done_o at N+6, out_o=0x00000001, busy_o falls at N+6.
REQ-032 Back-to-back: start_i held high for 3 operations -> done_o at N+6, N+12, N+18 with correct results; out_o stable between pulses.
REQ-033 Reset mid-op: assert rst_i in cycle N+3 -> out_o=0, busy_o=0, done_o=0 immediately; no done_o afterwards until a new start.
REQ-034 Random: 1000 random {in, shamt, arith} vectors against the REQ-025 model; any mismatch reports TEST FAILED, full pass reports TEST PASSED.

Source files
------------

// File: rtl/shift_right_seq_32b.sv
// Sequential barrel shifter: one log-stage per cycle, SRL or SRA,
// fixed latency of SHW+1 cycles from accept to done pulse.
module shift_right_seq_32b #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             arith_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHW-1:0] LAST_STAGE = SHW'(SHW - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] work, stage_val;
  logic [SHW-1:0]   shamt_r, cnt, step;
  logic             arith_r, sign_r, accept, last_stage;

  assign busy_o     = (state == SHIFT);
  assign done_o     = (state == DONE);
  assign accept     = start_i && (state != SHIFT);
  assign last_stage = (state == SHIFT) && (cnt == LAST_STAGE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_i) state_n = SHIFT;
      SHIFT:   if (cnt == LAST_STAGE) state_n = DONE;
      DONE:    state_n = start_i ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stage k shifts by 2^k; sign fill done by shifting the complement.
  always_comb begin
    step      = SHW'(1) << cnt;
    stage_val = work;
    if (shamt_r[cnt]) begin
      if (arith_r && sign_r) stage_val = ~((~work) >> step);
      else                   stage_val = work >> step;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work    <= '0;
      shamt_r <= '0;
      arith_r <= 1'b0;
      sign_r  <= 1'b0;
      cnt     <= '0;
      out_o   <= '0;
    end else if (accept) begin
      work    <= in_i;
      shamt_r <= shamt_i;
      arith_r <= arith_i;
      sign_r  <= in_i[WIDTH-1];
      cnt     <= '0;
    end else if (state == SHIFT) begin
      work <= stage_val;
      cnt  <= cnt + SHW'(1);
      if (last_stage) out_o <= stage_val;
    end
  end

endmodule

// File: tb/tb_shift_right_seq_32b.sv
// Directed-vector and corner-sequence bench for shift_right_seq_32b (WIDTH=32).
module tb_shift_right_seq_32b;

  logic        clk = 1'b0;
  logic        rst, start, arith, busy, done;
  logic [31:0] din, dout;
  logic [4:0]  shamt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  shift_right_seq_32b #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .arith_i(arith),
    .in_i(din), .shamt_i(shamt), .out_o(dout), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] in;
    logic [4:0]  sh;
    logic        ar;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, scramble operands while busy, return result and cycles to done.
  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic m,
                        output logic [31:0] res, output int lat);
    logic [31:0] prev;
    prev  = dout;
    din   = a; shamt = s; arith = m; start = 1'b1;
    tick();
    start = 1'b0;
    din   = ~a; shamt = ~s; arith = ~m;
    lat   = 1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    while (!done && lat < 20) begin
      if (lat == 3) chk("out_hold_in_shift", dout, prev);
      tick();
      lat++;
    end
    res = dout;
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s, input logic m);
    return m ? 32'($signed(a) >>> s) : (a >> s);
  endfunction

  initial begin
    logic [31:0] res, a, exp_q[3], ops[3];
    logic [4:0]  s;
    logic        m;
    int          lat;
    int          seen;

    vecs[0]  = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF};
    vecs[1]  = '{32'h80000000, 5'd31, 1'b0, 32'h00000001};
    vecs[2]  = '{32'hDEADBEEF, 5'd0,  1'b0, 32'hDEADBEEF};
    vecs[3]  = '{32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF};
    vecs[4]  = '{32'hF0F0F0F0, 5'd4,  1'b1, 32'hFF0F0F0F};
    vecs[5]  = '{32'hF0F0F0F0, 5'd4,  1'b0, 32'h0F0F0F0F};
    vecs[6]  = '{32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000};
    vecs[7]  = '{32'h12345678, 5'd16, 1'b0, 32'h00001234};
    vecs[8]  = '{32'h87654321, 5'd8,  1'b1, 32'hFF876543};
    vecs[9]  = '{32'hAAAAAAAA, 5'd1,  1'b1, 32'hD5555555};
    vecs[10] = '{32'hAAAAAAAA, 5'd1,  1'b0, 32'h55555555};

    rst = 1'b1; start = 1'b0; arith = 1'b0; din = '0; shamt = '0;
    #12;
    chk("reset_out",  dout, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].in, vecs[i].sh, vecs[i].ar, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd6);
      tick();
      chk($sformatf("vec%0d_done_single", i), {31'd0, done}, 32'd0);
    end

    // Busy protection: second start at N+2 must be ignored
    din = 32'h00000100; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    tick(); start = 1'b0; din = '0;
    tick();
    din = 32'hFFFFFFFF; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("busy_prot_done_n6", {31'd0, done}, 32'd1);
    chk("busy_prot_busy_n6", {31'd0, busy}, 32'd0);
    chk("busy_prot_result",  dout, 32'h00000001);
    tick();
    chk("busy_prot_no_second", {31'd0, done}, 32'd0);

    // Back-to-back with start held high
    ops[0] = 32'hC0000000; ops[1] = 32'h0000FF00; ops[2] = 32'h80000001;
    for (int k = 0; k < 3; k++) exp_q[k] = model(ops[k], 5'd4, 1'b1);
    din = ops[0]; shamt = 5'd4; arith = 1'b1; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lat = 0;
      do begin
        tick();
        lat++;
        if (lat == 1) begin
          if (k < 2) din = ops[k+1];
          else start = 1'b0;
        end
        if (lat == 3 && k > 0) chk($sformatf("b2b%0d_hold", k), dout, exp_q[k-1]);
      end while (!done && lat < 20);
      chk($sformatf("b2b%0d_latency", k), 32'(lat), 32'd6);
      chk($sformatf("b2b%0d_result", k), dout, exp_q[k]);
    end
    tick();

    // Reset mid-operation at N+3
    din = 32'hFFFF0000; shamt = 5'd3; arith = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out",  dout, 32'h0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_done", {31'd0, done}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) seen++;
    end
    chk("rst_no_done_after", 32'(seen), 32'd0);

    // First start right after reset release
    rst = 1'b1; tick(); rst = 1'b0;
    run_op(32'h00F00000, 5'd20, 1'b0, res, lat);
    chk("post_rst_latency", 32'(lat), 32'd6);
    chk("post_rst_result",  res, 32'h0000000F);
    tick();

    // Random vectors against the behavioural model
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; s = 5'($urandom_range(0, 31)); m = 1'($urandom_range(0, 1));
      run_op(a, s, m, res, lat);
      chk($sformatf("rand%0d", i), res, model(a, s, m));
      if (i % 2 == 0) tick();
    end

    if (n_bad == 0) $display("TEST PASSED");
    else            $display("TEST FAILED");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
